ball_split_mover: RTL

BALL_SPLIT_MOVER -- requirements
Module: ball_split_mover

---
 rtl/ball_split_mover.sv | 93 +++++++++
 1 files changed

// File: rtl/ball_split_mover.sv
// ball_split_mover: split-spawned ball with 1/64-pixel fixed-point motion and wall/floor bounces.
// Optional per-frame gravity is enabled by defining BALL_GRAVITY_EN.
module ball_split_mover #(
  parameter int FIXED_SHIFT  = 6,
  parameter int LEFT_LIMIT   = 0,
  parameter int RIGHT_LIMIT  = 600,
  parameter int FLOOR_Y      = 420,
  parameter int CEIL_Y       = 0,
  parameter int GRAVITY      = 4,
  parameter int BOUNCE_SPEED = 384,
  parameter int MAX_Y_SPEED  = 512
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               splitPulse,
  input  logic               killPulse,
  input  logic signed [10:0] Xspeed_in,
  input  logic signed [10:0] Yspeed_in,
  input  logic        [10:0] initX,
  input  logic        [10:0] initY,
  output logic        [10:0] topLeftX,
  output logic        [10:0] topLeftY,
  output logic               ballActive
);
  typedef enum logic {IDLE, MOVE} state_t;
  state_t state_q, state_d;
  logic [16:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [10:0] spd_x_q, spd_x_d, spd_y_q, spd_y_d, spd_x_n, spd_y_n;
  logic [10:0] tl_x, tl_y;
  logic floor_hit;
  // Signed speed added to an unsigned position; results below zero clamp to zero.
  function automatic logic [16:0] step(input logic [16:0] pos, input logic signed [10:0] spd);
    logic signed [17:0] sum;
    sum = $signed({1'b0, pos}) + $signed({{7{spd[10]}}, spd});
    return sum[17] ? 17'd0 : sum[16:0];
  endfunction
  assign tl_x = 11'(pos_x_q >> FIXED_SHIFT);
  assign tl_y = 11'(pos_y_q >> FIXED_SHIFT);
  assign topLeftX = tl_x;
  assign topLeftY = tl_y;
  assign ballActive = state_q == MOVE;
  assign spd_x_n = ((tl_x <= 11'(LEFT_LIMIT) && spd_x_q < 0) ||
                    (tl_x >= 11'(RIGHT_LIMIT) && spd_x_q > 0)) ? -spd_x_q : spd_x_q;
  assign floor_hit = tl_y >= 11'(FLOOR_Y) && spd_y_q > 0;
`ifdef BALL_GRAVITY_EN
  logic signed [10:0] spd_y_b;
  logic signed [11:0] y_sum;
  assign spd_y_b = floor_hit ? 11'(-BOUNCE_SPEED) : spd_y_q;
  assign y_sum = {spd_y_b[10], spd_y_b} + 12'(GRAVITY);
  assign spd_y_n = (y_sum > $signed(12'(MAX_Y_SPEED))) ? 11'(MAX_Y_SPEED) : y_sum[10:0];
`else
  logic ceil_hit;
  assign ceil_hit = tl_y <= 11'(CEIL_Y) && spd_y_q < 0;
  assign spd_y_n = (floor_hit || ceil_hit) ? -spd_y_q : spd_y_q;
`endif
  always_comb begin
    state_d = state_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    spd_x_d = spd_x_q;
    spd_y_d = spd_y_q;
    if (killPulse) begin
      state_d = IDLE;
    end else if (splitPulse) begin
      state_d = MOVE;
      pos_x_d = 17'(initX) << FIXED_SHIFT;
      pos_y_d = 17'(initY) << FIXED_SHIFT;
      spd_x_d = Xspeed_in;
      spd_y_d = Yspeed_in;
    end else if (state_q == MOVE && startOfFrame) begin
      spd_x_d = spd_x_n;
      spd_y_d = spd_y_n;
      pos_x_d = step(pos_x_q, spd_x_n);
      pos_y_d = step(pos_y_q, spd_y_n);
    end
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      pos_x_q <= '0;
      pos_y_q <= '0;
      spd_x_q <= '0;
      spd_y_q <= '0;
    end else begin
      state_q <= state_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      spd_x_q <= spd_x_d;
      spd_y_q <= spd_y_d;
    end
  end
endmodule
